// File: rtl/prog_seq_if.sv
// Handshake and fetch-control bundle between the sequencer and its
// driver (decode/ALU side and the testbench Start/Ack handshake).
interface prog_seq_if #(
    parameter int PW = 10,
    parameter int CW = 16
);
    logic          Start;
    logic          Branch;
    logic          BranchEn;
    logic          JumpRel;
    logic [PW-1:0] Target;
    logic          Halt;
    logic          Stall;
    logic [PW-1:0] ProgCtr;
    logic          Running;
    logic          Ack;
    logic [CW-1:0] CycleCnt;

    modport master (
        output Start, Branch, BranchEn, JumpRel, Target, Halt, Stall,
        input  ProgCtr, Running, Ack, CycleCnt
    );

    modport slave (
        input  Start, Branch, BranchEn, JumpRel, Target, Halt, Stall,
        output ProgCtr, Running, Ack, CycleCnt
    );
endinterface

// File: rtl/prog_seq.sv
// Program-counter sequencer: fetch address generation, BNZ resolution,
// Start/Ack handshake and a saturating RUN-cycle counter.
module prog_seq #(
    parameter int PW = 10,
    parameter int CW = 16
) (
    input  logic      Clk,
    input  logic      Reset,
    prog_seq_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        DONE
    } state_t;

    state_t state;

    localparam logic [CW-1:0] CNT_MAX = '1;

    logic          taken;
    logic [PW-1:0] br_pc;

    assign taken = bus.BranchEn & bus.Branch;
    assign br_pc = bus.JumpRel ? bus.ProgCtr + bus.Target : bus.Target;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            bus.ProgCtr  <= '0;
            bus.Running  <= 1'b0;
            bus.Ack      <= 1'b0;
            bus.CycleCnt <= '0;
        end else if (bus.Start) begin
            state        <= ARMED;
            bus.ProgCtr  <= '0;
            bus.Running  <= 1'b0;
            bus.Ack      <= 1'b0;
            bus.CycleCnt <= '0;
        end else begin
            unique case (state)
                IDLE: ;
                ARMED: begin
                    state       <= RUN;
                    bus.Running <= 1'b1;
                end
                RUN: begin
                    if (bus.CycleCnt != CNT_MAX)
                        bus.CycleCnt <= bus.CycleCnt + 1'b1;
                    // Stall outranks halt and branch: the PC is simply frozen
                    if (bus.Stall) begin
                        bus.ProgCtr <= bus.ProgCtr;
                    end else if (bus.Halt) begin
                        state       <= DONE;
                        bus.Running <= 1'b0;
                        bus.Ack     <= 1'b1;
                    end else if (taken) begin
                        bus.ProgCtr <= br_pc;
                    end else begin
                        bus.ProgCtr <= bus.ProgCtr + 1'b1;
                    end
                end
                DONE: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
